mem_controller: RTL and testbench
=================================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 The block SHALL have parameter LEN_W, default 3, burst-length field width; a burst is len+1 beats, 1..8.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock, shared with the RAM.
- reset_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have these CPU-side ports:
- req  in  1  request valid.
- wr  in  1  1 = write burst, 0 = read burst; sampled with req.
- addr  in  ADDR_W  burst start address.
- len  in  LEN_W  beats minus one.
- wdata  in  DATA_W  current write word.
- ready  out  1  idle, able to accept req.
- wdata_take  out  1  wdata is consumed this cycle.
- rdata  out  DATA_W  read word.
- rdata_valid  out  1  rdata is valid this cycle.
- done  out  1  one-cycle pulse at burst completion.
REQ-006 The block SHALL have these RAM-side ports:
- mem_read  out  1  RAM read enable.
- mem_write  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM registered read data, valid one cycle after mem_read.

Function
REQ-007 The FSM SHALL have states IDLE, RD, WR, DONE, held in a registered state variable.
REQ-008 ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where req=1 and ready=1.
REQ-009 On acceptance, the block SHALL latch addr into cur_addr, len into beats_left, and wr into the direction bit, then enter WR (wr=1) or RD (wr=0).
REQ-010 req SHALL be ignored in RD, WR and DONE, with no queuing.
REQ-011 In RD the block SHALL drive mem_read=1 and mem_addr=cur_addr for exactly len+1 consecutive cycles, one beat per cycle.
REQ-012 rdata_valid SHALL be a register set in every cycle that follows a cycle with mem_read=1.
REQ-013 rdata SHALL equal mem_dout combinationally, giving a read latency of 1 cycle per beat.
REQ-014 In WR the block SHALL drive mem_write=1, mem_addr=cur_addr, mem_din=wdata and wdata_take=1 for exactly len+1 consecutive cycles; the producer SHALL present the next word in the cycle after each take.
REQ-015 cur_addr SHALL increment by 1 per beat and wrap from 2^ADDR_W-1 to 0.
REQ-016 beats_left SHALL decrement per beat; the beat with beats_left=0 SHALL be the last, after which the FSM enters DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 For a read burst, the final rdata_valid SHALL coincide with done.
REQ-019 mem_read and mem_write SHALL never be 1 in the same cycle.
REQ-020 mem_read, mem_write and wdata_take SHALL be 0 in IDLE and DONE.
REQ-021 mem_din SHALL be 0 outside WR.
REQ-022 Back-to-back bursts SHALL have a minimum spacing of 1 idle cycle: after DONE, IDLE, accept, next beat.

Reset
REQ-023 While reset_n=0, asynchronously: state=IDLE, cur_addr=0, beats_left=0, direction=0, rdata_valid=0.
REQ-024 Output values in reset SHALL be: ready=1, mem_read=0, mem_write=0, wdata_take=0, done=0, mem_addr=0, mem_din=0.
REQ-025 Reset asserted mid-burst SHALL abort the burst immediately, with no further RAM strobes and no done pulse; RAM contents already written SHALL remain.

Structure
REQ-026 A shared package SHALL hold ADDR_W/DATA_W/LEN_W defaults and the state enumeration (IDLE, RD, WR, DONE).
REQ-027 The block SHALL be a single module with no sub-module; address and beat counters stay inline.

Verification
REQ-028 Single write then read: wr=1, addr=0x010, len=0, wdata=0xDEADBEEF; then wr=0, addr=0x010, len=0 -> one mem_write cycle; rdata=0xDEADBEEF with rdata_valid 1 cycle after mem_read, coincident with done.
REQ-029 Burst write/read: len=7, addr=0x020, wdata 0x1..0x8 on successive takes -> 8 consecutive mem_write cycles at 0x020..0x027; read-back gives 8 consecutive rdata_valid with 0x1..0x8 and done on the 8th.
REQ-030 Wrap-around: wr=1, addr=0x1FE, len=3 -> mem_addr sequence 0x1FE, 0x1FF, 0x000, 0x001.
REQ-031 Busy ignore: hold req=1 with new fields during a len=3 read -> exactly one burst executes; the second request is accepted only in the IDLE cycle after done.
REQ-032 Reset mid-burst: reset_n low on the 3rd beat of a len=7 write -> mem_write=0 in the same cycle, ready=1, no done; addresses 0..1 of the burst hold new data and later addresses keep old data.
REQ-033 Checker: mem_read and mem_write are never both 1, and rdata_valid count equals len+1 per read burst, over 1000 random bursts.

Source files
------------

// File: rtl/mem_controller_pkg.sv
// ============================================================================
// mem_controller_pkg : shared defaults and FSM state encoding
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_controller_pkg;

  localparam int c_ADDR_W = 9;
  localparam int c_DATA_W = 32;
  localparam int c_LEN_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_controller.sv
// ============================================================================
// mem_controller : single-port RAM burst controller, 1..8 beats per burst
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_controller
  import mem_controller_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W,
  parameter int LEN_W  = c_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  // CPU side
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              wdata_take,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  // RAM side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [ADDR_W-1:0] c_ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  c_LEN_ONE  = 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_beats_left;
  logic              r_dir;
  logic              r_rdata_valid;
  logic              w_accept;
  logic              w_beat;
  logic              w_last;

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    wdata_take  = 1'b0;
    done        = 1'b0;
    mem_addr    = '0;
    mem_din     = '0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    w_last      = (r_beats_left == '0);
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = wr ? WR : RD;
        end
      end
      // Strobes are also gated by the latched direction so the two can
      // never overlap even if the state register were corrupted.
      RD: begin
        mem_read = ~r_dir;
        mem_addr = r_cur_addr;
        w_beat   = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      WR: begin
        mem_write  = r_dir;
        mem_addr   = r_cur_addr;
        mem_din    = wdata;
        wdata_take = 1'b1;
        w_beat     = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_addr    <= '0;
      r_beats_left  <= '0;
      r_dir         <= 1'b0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= mem_read;
      if (w_accept) begin
        r_cur_addr   <= addr;
        r_beats_left <= len;
        r_dir        <= wr;
      end else if (w_beat) begin
        r_cur_addr <= r_cur_addr + c_ADDR_ONE;
        if (!w_last) r_beats_left <= r_beats_left - c_LEN_ONE;
      end
    end
  end

  // RAM output is already registered, so read data passes straight through.
  assign rdata       = mem_dout;
  assign rdata_valid = r_rdata_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_controller.sv
// ============================================================================
// tb_mem_controller : directed and random bursts against a registered RAM
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_controller;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        wr;
  logic [8:0]  addr;
  logic [2:0]  len;
  logic [31:0] wdata;
  logic        ready;
  logic        wdata_take;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        mem_read;
  logic        mem_write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] ram   [0:511];
  logic [31:0] model [0:511];

  int n_checks = 0;
  int n_errors = 0;
  int n_both   = 0;

  mem_controller #(.ADDR_W(9), .DATA_W(32), .LEN_W(3)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .wr         (wr),
    .addr       (addr),
    .len        (len),
    .wdata      (wdata),
    .ready      (ready),
    .wdata_take (wdata_take),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .done       (done),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output single-port RAM
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr] <= mem_din;
    if (mem_read)  mem_dout      <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called between edges with ready=1; returns at a negedge with ready=1.
  task automatic write_burst(input logic [8:0] a, input logic [2:0] l, input logic [31:0] d0);
    logic [8:0] ea;
    req = 1'b1; wr = 1'b1; addr = a; len = l; wdata = d0;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      ea    = a + 9'(i);
      wdata = d0 + 32'(i);
      @(negedge clk);
      check("wr_strobe", 32'(mem_write), 32'd1);
      check("wr_take",   32'(wdata_take), 32'd1);
      check("wr_addr",   32'(mem_addr), 32'(ea));
      check("wr_din",    mem_din, d0 + 32'(i));
      model[ea] = d0 + 32'(i);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wr_done",     32'(done), 32'd1);
    check("wr_done_off", 32'(mem_write), 32'd0);
    check("wr_din_zero", mem_din, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_ready", 32'(ready), 32'd1);
    check("wr_done_pulse", 32'(done), 32'd0);
  endtask

  task automatic read_burst(input logic [8:0] a, input logic [2:0] l);
    logic [8:0] ea;
    int nv;
    nv = 0;
    req = 1'b1; wr = 1'b0; addr = a; len = l;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 9'(i);
      @(negedge clk);
      check("rd_strobe", 32'(mem_read), 32'd1);
      check("rd_no_wr",  32'(mem_write), 32'd0);
      check("rd_addr",   32'(mem_addr), 32'(ea));
      if (rdata_valid) nv++;
      if (i == 0) check("rd_valid0", 32'(rdata_valid), 32'd0);
      else        check("rd_data", rdata, model[ea - 9'd1]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    if (rdata_valid) nv++;
    check("rd_done",       32'(done), 32'd1);
    check("rd_last_valid", 32'(rdata_valid), 32'd1);
    check("rd_last_data",  rdata, model[a + 9'(l)]);
    check("rd_no_strobe",  32'(mem_read), 32'd0);
    check("rd_nvalid",     32'(nv), 32'(int'(l) + 1));
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_valid_off", 32'(rdata_valid), 32'd0);
    check("rd_ready",     32'(ready), 32'd1);
  endtask

  initial begin
    logic [8:0] ra;
    logic [2:0] rl;
    reset_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; len = '0; wdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready",  32'(ready), 32'd1);
    check("rst_read",   32'(mem_read), 32'd0);
    check("rst_write",  32'(mem_write), 32'd0);
    check("rst_take",   32'(wdata_take), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_addr",   32'(mem_addr), 32'd0);
    check("rst_din",    mem_din, 32'd0);
    check("rst_rvalid", 32'(rdata_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Fill the whole RAM so every later read has defined contents
    for (int k = 0; k < 64; k++) write_burst(9'(k * 8), 3'd7, $urandom);

    // Single write then read
    write_burst(9'h010, 3'd0, 32'hDEAD_BEEF);
    read_burst(9'h010, 3'd0);
    check("single_data", model[9'h010], 32'hDEAD_BEEF);

    // Eight-beat burst, data 1..8
    write_burst(9'h020, 3'd7, 32'd1);
    read_burst(9'h020, 3'd7);

    // Address wrap 0x1FE -> 0x001
    write_burst(9'h1FE, 3'd3, 32'h0000_00A0);
    read_burst(9'h1FE, 3'd3);

    // Request held high during a busy read is not queued
    req = 1'b1; wr = 1'b0; addr = 9'h040; len = 3'd3;
    @(posedge clk); #1;
    wr = 1'b1; addr = 9'h100; len = 3'd0; wdata = 32'h0000_0055;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_rd",    32'(mem_read), 32'd1);
      check("busy_addr",  32'(mem_addr), 32'(9'h040 + 9'(i)));
      check("busy_nowr",  32'(mem_write), 32'd0);
      check("busy_ready", 32'(ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("busy_done",  32'(done), 32'd1);
    check("busy_ready_done", 32'(ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_idle",  32'(ready), 32'd1);
    check("busy_idle_nowr", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("busy_acc_wr",   32'(mem_write), 32'd1);
    check("busy_acc_addr", 32'(mem_addr), 32'h100);
    check("busy_acc_din",  mem_din, 32'h55);
    model[9'h100] = 32'h55;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_acc_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    read_burst(9'h100, 3'd0);

    // Reset in the third beat of an eight-beat write
    write_burst(9'h080, 3'd7, 32'h0000_1000);
    req = 1'b1; wr = 1'b1; addr = 9'h080; len = 3'd7; wdata = 32'h0000_2000;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wdata = 32'h0000_2000 + 32'(i);
      @(negedge clk);
      check("abort_beat", 32'(mem_write), 32'd1);
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    #1 reset_n = 1'b0;
    #1;
    check("abort_write", 32'(mem_write), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done",  32'(done), 32'd0);
    check("abort_take",  32'(wdata_take), 32'd0);
    check("abort_addr",  32'(mem_addr), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_hold_done",  32'(done), 32'd0);
      check("abort_hold_write", 32'(mem_write), 32'd0);
    end
    reset_n = 1'b1;
    model[9'h080] = 32'h0000_2000;
    model[9'h081] = 32'h0000_2001;
    read_burst(9'h080, 3'd7);
    check("abort_old", model[9'h082], 32'h0000_1002);

    // Random bursts
    for (int k = 0; k < 1000; k++) begin
      ra = 9'($urandom);
      rl = 3'($urandom);
      if ($urandom_range(0, 1) == 1) write_burst(ra, rl, $urandom);
      else                           read_burst(ra, rl);
    end

    check("never_both", 32'(n_both), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
